bcrypt_core_rx: RTL and testbench
=================================

// Module: bcrypt_core_rx
// PURPOSE
//  Receiving end of the 10-bit bcrypt_data -> core bus (8-bit data + 2-bit ctrl), one per core.
//  Reassembles little-endian 32-bit words and writes them into the core's P/S/data memory.
//  Two transfer types: INIT (P constants + S boxes) and DATA (per-candidate key/salt/cmp block).
//  Checks framing, raises sticky errors, and pulses done flags to the core FSM.
// PARAMETERS
//  P_WORDS   30    words in the INIT P section (addr 0..29)
//  S_WORDS   1024  words in the INIT S section (addr S_BASE..S_BASE+1023)
//  D_WORDS   31    words in a DATA transfer (addr D_BASE..D_BASE+30)
//  S_BASE    1024  S-section base address
//  D_BASE    32    DATA-section base address
//  ADDR_W    11    memory address width
// PORTS
//  CLK         in   1       clock
//  RST_N       in   1       reset, asynchronous, active-low
//  din         in   8       bus data byte
//  ctrl        in   2       bus control: 0 idle/data, `CTRL_INIT_START, `CTRL_DATA_START, `CTRL_END (bcrypt.vh)
//  core_busy   in   1       core is computing; DATA memory must not be overwritten
//  mem_wr_en   out  1       memory write strobe
//  mem_addr    out  ADDR_W  memory write address
//  mem_wdata   out  32      memory write data
//  init_loaded out  1       level: a full INIT transfer has been received since reset
//  init_done   out  1       1-cycle pulse, INIT transfer complete
//  data_done   out  1       1-cycle pulse, DATA transfer complete
//  error       out  3       sticky: [0] length/alignment, [1] START during transfer, [2] protocol
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, init_loaded 0; reset mid-transfer discards partial data.
//  Bus framing: one cycle with ctrl=START (din don't-care); then 4*N bytes on consecutive cycles,
//   byte 0 = word[7:0] ... byte 3 = word[31:24]; ctrl=END is sampled together with the last byte.
//   No gaps inside a transfer.
//  States: IDLE, RX_INIT, RX_DATA, ERROR.
//  IDLE: ctrl=INIT_START -> RX_INIT, word_cnt=0, byte_cnt=0.
//   ctrl=DATA_START -> RX_DATA if init_loaded && !core_busy, else error[2], -> ERROR.
//   ctrl=END in IDLE -> error[2], -> ERROR. ctrl=0 ignored.
//  RX_*: each cycle shift din into word_reg at byte_cnt; byte_cnt wraps 3->0.
//   On byte_cnt==3: register write, issued the next cycle (mem_wr_en=1 for exactly one cycle).
//   Write latency: 1 cycle after the 4th byte is sampled.
//   INIT addr: word_cnt<P_WORDS -> word_cnt; else S_BASE+(word_cnt-P_WORDS). DATA addr: D_BASE+word_cnt.
//   word_cnt width ADDR_W; increments after each completed word.
//  END handling: valid only if byte_cnt==3 and word_cnt==expected-1 (INIT: P_WORDS+S_WORDS-1, DATA: D_WORDS-1).
//   Valid: last word written, then init_done / data_done pulses in the cycle after that write; -> IDLE.
//   INIT completion sets init_loaded=1 (stays set until reset).
//   Invalid (early END, END mid-word): error[0], no pending write issued, -> ERROR.
//  Overrun: word count reaching expected without END -> error[0], -> ERROR.
//  Any START seen during RX_* -> error[1], -> ERROR (simultaneous START+END impossible: single ctrl field).
//  ERROR: terminal; bus ignored, no writes, no done pulses; only RST_N exits. Error bits never clear otherwise.
//  A new START may arrive in the cycle after END; it must be accepted (done pulse and next start overlap OK).
//  gen_end DATA transfers put nothing on the bus; the block sees no activity.
// TESTING
//  1. INIT: START, 30 P + 1024 S words, END on last byte -> 1054 writes, addr 0..29 then 1024..2047,
//     init_done pulse, init_loaded=1.
//  2. DATA after INIT: bytes 78 56 34 12 first -> mem_addr=32, mem_wdata=0x12345678;
//     31 writes to 32..62, data_done pulse 1 cycle after the last write.
//  3. DATA_START before any INIT, or while core_busy=1 -> error=3'b100, no writes, further bus traffic ignored.
//  4. DATA with END on word 20 byte 3 -> error[0]=1, 20 writes only, no data_done.
//     END on byte 1 -> error[0]=1, partial word not written.
//  5. INIT_START during RX_DATA -> error[1]=1, state ERROR.
//     RST_N low mid-INIT -> all outputs 0, init_loaded=0; a fresh INIT then succeeds.
//  6. Back-to-back: DATA END followed next cycle by DATA_START -> both transfers complete, two data_done pulses.

Source files
------------

// File: rtl/bcrypt_core_rx_if.sv
// Shared control-code package and the 10-bit bcrypt_data -> core bus interface.
package bcrypt_core_rx_pkg;
  localparam logic [1:0] CTRL_IDLE       = 2'd0;
  localparam logic [1:0] CTRL_INIT_START = 2'd1;
  localparam logic [1:0] CTRL_DATA_START = 2'd2;
  localparam logic [1:0] CTRL_END        = 2'd3;
endpackage

interface bcrypt_core_rx_if;
  logic [7:0] din;
  logic [1:0] ctrl;

  modport master (output din, output ctrl);
  modport slave  (input  din, input  ctrl);
endinterface

// File: rtl/bcrypt_core_rx.sv
// Per-core bus receiver: reassembles little-endian words from the byte bus and
// writes INIT (P/S) or DATA blocks into core memory, with sticky framing errors.
module bcrypt_core_rx
  import bcrypt_core_rx_pkg::*;
#(
  parameter int P_WORDS = 30,
  parameter int S_WORDS = 1024,
  parameter int D_WORDS = 31,
  parameter int S_BASE  = 1024,
  parameter int D_BASE  = 32,
  parameter int ADDR_W  = 11
) (
  input  logic              CLK,
  input  logic              RST_N,
  bcrypt_core_rx_if.slave   bus,
  input  logic              core_busy,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              init_loaded,
  output logic              init_done,
  output logic              data_done,
  output logic [2:0]        error
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RX_INIT,
    ST_RX_DATA,
    ST_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] INIT_LAST = ADDR_W'(P_WORDS + S_WORDS - 1);
  localparam logic [ADDR_W-1:0] DATA_LAST = ADDR_W'(D_WORDS - 1);

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic [23:0]       word_reg;
  logic              init_pend;
  logic              data_pend;

  logic [ADDR_W-1:0] wr_addr_c;
  logic              last_word_c;
  logic [31:0]       word_c;
  logic              is_start_c;
  logic              is_end_c;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and a latch can never be inferred.
  always_comb begin
    wr_addr_c   = '0;
    last_word_c = 1'b0;
    word_c      = {bus.din, word_reg};
    is_start_c  = (bus.ctrl == CTRL_INIT_START) || (bus.ctrl == CTRL_DATA_START);
    is_end_c    = (bus.ctrl == CTRL_END);
    if (state == ST_RX_INIT) begin
      last_word_c = (word_cnt == INIT_LAST);
      if (word_cnt < ADDR_W'(P_WORDS))
        wr_addr_c = word_cnt;
      else
        wr_addr_c = ADDR_W'(S_BASE) + (word_cnt - ADDR_W'(P_WORDS));
    end else begin
      last_word_c = (word_cnt == DATA_LAST);
      wr_addr_c   = ADDR_W'(D_BASE) + word_cnt;
    end
  end

  // NOTE: all registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      byte_cnt    <= '0;
      word_cnt    <= '0;
      word_reg    <= '0;
      init_pend   <= 1'b0;
      data_pend   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      init_loaded <= 1'b0;
      init_done   <= 1'b0;
      data_done   <= 1'b0;
      error       <= '0;
    end else begin
      mem_wr_en <= 1'b0;
      // Done pulses trail the final write by one cycle.
      init_done <= init_pend;
      data_done <= data_pend;
      init_pend <= 1'b0;
      data_pend <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          byte_cnt <= '0;
          word_cnt <= '0;
          unique case (bus.ctrl)
            CTRL_INIT_START: state <= ST_RX_INIT;
            CTRL_DATA_START: begin
              if (init_loaded && !core_busy) begin
                state <= ST_RX_DATA;
              end else begin
                error[2] <= 1'b1;
                state    <= ST_ERROR;
              end
            end
            CTRL_END: begin
              error[2] <= 1'b1;
              state    <= ST_ERROR;
            end
            default: ;
          endcase
        end

        ST_RX_INIT, ST_RX_DATA: begin
          if (is_start_c) begin
            error[1] <= 1'b1;
            state    <= ST_ERROR;
          end else if (byte_cnt != 2'd3) begin
            word_reg <= {bus.din, word_reg[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (is_end_c) begin
              error[0] <= 1'b1;
              state    <= ST_ERROR;
            end
          end else begin
            byte_cnt <= '0;
            // END must coincide exactly with the last byte of the last word;
            // early END or running past the last word are both length errors.
            if (is_end_c != last_word_c) begin
              error[0] <= 1'b1;
              state    <= ST_ERROR;
            end else begin
              mem_wr_en <= 1'b1;
              mem_addr  <= wr_addr_c;
              mem_wdata <= word_c;
              word_cnt  <= word_cnt + 1'b1;
              if (is_end_c) begin
                state <= ST_IDLE;
                if (state == ST_RX_INIT) begin
                  init_pend   <= 1'b1;
                  init_loaded <= 1'b1;
                end else begin
                  data_pend <= 1'b1;
                end
              end
            end
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcrypt_core_rx.sv
// Directed bench for bcrypt_core_rx: full INIT/DATA transfers, framing errors,
// back-to-back transfers and reset mid-transfer, checked by a write monitor.
module tb_bcrypt_core_rx;
  import bcrypt_core_rx_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        core_busy = 1'b0;
  logic        mem_wr_en;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        init_loaded, init_done, data_done;
  logic [2:0]  error;

  bcrypt_core_rx_if bus_if ();

  bcrypt_core_rx dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus_if), .core_busy(core_busy),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .init_loaded(init_loaded), .init_done(init_done), .data_done(data_done),
    .error(error)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] base, input int w);
    return base + 32'(w) * 32'h01020304;
  endfunction

  function automatic logic [10:0] exp_addr(input int mode, input int idx);
    if (mode == 1) return 11'(32 + idx);
    if (idx < 30) return 11'(idx);
    return 11'(1024 + idx - 30);
  endfunction

  // Monitor: samples 1 ns after each rising edge; sole writer of its counters.
  int          mon_mode = 0;
  logic [31:0] tx_base = '0;
  logic        mon_clr = 1'b0;
  int          cyc = 0, wr_cnt = 0, addr_bad = 0, data_bad = 0;
  int          idone_cnt = 0, ddone_cnt = 0, last_wr_cyc = 0, idone_cyc = 0, ddone_cyc = 0;
  logic [10:0] first_addr = '0;
  logic [31:0] first_data = '0;
  int          mon_idx;

  always @(posedge CLK) begin
    #1;
    cyc++;
    if (mon_clr) begin
      wr_cnt = 0; addr_bad = 0; data_bad = 0; idone_cnt = 0; ddone_cnt = 0;
      last_wr_cyc = 0; idone_cyc = 0; ddone_cyc = 0; first_addr = '0; first_data = '0;
    end else begin
      if (mem_wr_en) begin
        mon_idx = (mon_mode == 1) ? (wr_cnt % 31) : wr_cnt;
        if (wr_cnt == 0) begin
          first_addr = mem_addr;
          first_data = mem_wdata;
        end
        if (mem_addr !== exp_addr(mon_mode, mon_idx)) addr_bad++;
        if (mem_wdata !== pat(tx_base, mon_idx)) data_bad++;
        wr_cnt++;
        last_wr_cyc = cyc;
      end
      if (init_done) begin idone_cnt++; idone_cyc = cyc; end
      if (data_done) begin ddone_cnt++; ddone_cyc = cyc; end
    end
  end

  task automatic clear_mon();
    @(negedge CLK); mon_clr = 1'b1;
    @(negedge CLK); mon_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0; bus_if.ctrl = CTRL_IDLE; bus_if.din = '0; core_busy = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    clear_mon();
  endtask

  // START, then nwords words; END (or ins_ctrl) replaces ctrl at the given
  // word/byte and stops the stream. tail=0 returns right after the last byte.
  task automatic send(input logic [1:0] start, input int nwords, input int end_w, input int end_b,
                      input int ins_w, input int ins_b, input logic [1:0] ins_ctrl,
                      input logic [31:0] base, input bit tail);
    logic [31:0] wv;
    bit stop;
    stop = 1'b0;
    @(negedge CLK);
    tx_base = base; bus_if.ctrl = start; bus_if.din = 8'h00;
    for (int w = 0; w < nwords; w++) begin
      wv = pat(base, w);
      for (int b = 0; b < 4; b++) begin
        if (!stop) begin
          @(negedge CLK);
          bus_if.din  = wv[8*b +: 8];
          bus_if.ctrl = (w == end_w && b == end_b) ? CTRL_END :
                        (w == ins_w && b == ins_b) ? ins_ctrl : CTRL_IDLE;
          if (bus_if.ctrl != CTRL_IDLE) stop = 1'b1;
        end
      end
    end
    if (tail) begin
      @(negedge CLK); bus_if.ctrl = CTRL_IDLE; bus_if.din = '0;
      repeat (4) @(negedge CLK);
    end
  endtask

  localparam logic [31:0] IBASE = 32'hC0DE0000;
  localparam logic [31:0] DBASE = 32'h12345678;

  task automatic run_init(input string tag);
    mon_mode = 0;
    clear_mon();
    send(CTRL_INIT_START, 1054, 1053, 3, -1, 0, CTRL_IDLE, IBASE, 1'b1);
    check({tag, "_writes"}, wr_cnt, 1054);
    check({tag, "_addr_bad"}, addr_bad, 0);
    check({tag, "_idone"}, idone_cnt, 1);
    check({tag, "_loaded"}, init_loaded, 1);
  endtask

  initial begin
    bus_if.ctrl = CTRL_IDLE;
    bus_if.din  = '0;
    repeat (2) @(negedge CLK);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_loaded", init_loaded, 0);
    check("rst_idone", init_done, 0);
    check("rst_ddone", data_done, 0);
    check("rst_error", error, 0);
    RST_N = 1'b1;
    clear_mon();

    // DATA before any INIT, then further traffic must be ignored.
    mon_mode = 1;
    send(CTRL_DATA_START, 31, 30, 3, -1, 0, CTRL_IDLE, DBASE, 1'b1);
    check("noinit_error", error, 3'b100);
    check("noinit_writes", wr_cnt, 0);
    send(CTRL_INIT_START, 40, 39, 3, -1, 0, CTRL_IDLE, IBASE, 1'b1);
    check("err_ignore_writes", wr_cnt, 0);
    check("err_ignore_idone", idone_cnt, 0);
    check("err_sticky", error, 3'b100);

    // Full INIT.
    do_reset();
    run_init("init1");
    check("init1_data_bad", data_bad, 0);
    check("init1_first_addr", first_addr, 0);
    check("init1_done_lat", idone_cyc - last_wr_cyc, 1);
    check("init1_error", error, 0);

    // Full DATA after INIT.
    mon_mode = 1;
    clear_mon();
    send(CTRL_DATA_START, 31, 30, 3, -1, 0, CTRL_IDLE, DBASE, 1'b1);
    check("data_first_addr", first_addr, 32);
    check("data_first_wdata", first_data, 32'h12345678);
    check("data_writes", wr_cnt, 31);
    check("data_addr_bad", addr_bad, 0);
    check("data_data_bad", data_bad, 0);
    check("data_ddone", ddone_cnt, 1);
    check("data_done_lat", ddone_cyc - last_wr_cyc, 1);

    // Back-to-back DATA transfers: START in the cycle after END.
    clear_mon();
    send(CTRL_DATA_START, 31, 30, 3, -1, 0, CTRL_IDLE, DBASE, 1'b0);
    send(CTRL_DATA_START, 31, 30, 3, -1, 0, CTRL_IDLE, DBASE, 1'b1);
    check("b2b_writes", wr_cnt, 62);
    check("b2b_addr_bad", addr_bad, 0);
    check("b2b_ddone", ddone_cnt, 2);
    check("b2b_done_lat", ddone_cyc - last_wr_cyc, 1);
    check("b2b_error", error, 0);

    // Early END on word 20 byte 3.
    clear_mon();
    send(CTRL_DATA_START, 31, 20, 3, -1, 0, CTRL_IDLE, DBASE, 1'b1);
    check("early_end_error", error, 3'b001);
    check("early_end_writes", wr_cnt, 20);
    check("early_end_ddone", ddone_cnt, 0);

    // END mid-word (word 5 byte 1).
    do_reset();
    run_init("init2");
    mon_mode = 1;
    clear_mon();
    send(CTRL_DATA_START, 31, 5, 1, -1, 0, CTRL_IDLE, DBASE, 1'b1);
    check("midword_error", error, 3'b001);
    check("midword_writes", wr_cnt, 5);

    // DATA_START while the core is busy.
    do_reset();
    run_init("init3");
    mon_mode = 1;
    clear_mon();
    core_busy = 1'b1;
    send(CTRL_DATA_START, 31, 30, 3, -1, 0, CTRL_IDLE, DBASE, 1'b1);
    core_busy = 1'b0;
    check("busy_error", error, 3'b100);
    check("busy_writes", wr_cnt, 0);
    check("busy_ddone", ddone_cnt, 0);

    // INIT_START during RX_DATA.
    do_reset();
    run_init("init4");
    mon_mode = 1;
    clear_mon();
    send(CTRL_DATA_START, 31, -1, 0, 3, 2, CTRL_INIT_START, DBASE, 1'b1);
    check("start_in_rx_error", error, 3'b010);
    check("start_in_rx_writes", wr_cnt, 3);

    // Reset in the middle of a second INIT, then a fresh INIT.
    do_reset();
    run_init("init5");
    mon_mode = 0;
    send(CTRL_INIT_START, 100, -1, 0, -1, 0, CTRL_IDLE, IBASE, 1'b0);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("midrst_loaded", init_loaded, 0);
    check("midrst_wr_en", mem_wr_en, 0);
    check("midrst_addr", mem_addr, 0);
    check("midrst_error", error, 0);
    bus_if.ctrl = CTRL_IDLE;
    @(negedge CLK);
    RST_N = 1'b1;
    run_init("init6");
    check("init6_error", error, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
